// File: rtl/dmem_arb.sv
// Two-port arbiter sharing one dmem_ctrl between the CPU LSU (port 0) and a secondary master (port 1).
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module dmem_arb (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req0,
  input  logic [17:0] addr0,
  input  logic [31:0] wdata0,
  input  logic [2:0]  memop0,
  input  logic        we0,
  input  logic        req1,
  input  logic [17:0] addr1,
  input  logic [31:0] wdata1,
  input  logic [2:0]  memop1,
  input  logic        we1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic [17:0] mem_addr,
  output logic [31:0] mem_datain,
  output logic [2:0]  mem_memop,
  output logic        mem_we,
  input  logic [31:0] mem_dataout
);

  localparam logic [1:0] OP_BYTE = 2'b00;
  localparam logic [1:0] OP_HALF = 2'b01;
  localparam logic [1:0] OP_WORD = 2'b10;

  logic        last_q, last_d;
  logic        rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic        err0_q, err0_d, err1_q, err1_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic        granted, pick1, sel_we, bad;

  // NOTE: every signal assigned in this block gets a default first so no latch is inferred.
  always_comb begin
    pick1 = req1 & ~req0;
    if (req0 && req1) begin
`ifdef DMEM_ARB_RR_EN
      pick1 = ~last_q;
`else
      pick1 = 1'b0;
`endif
    end
    granted = rstn & (req0 | req1);
    gnt0    = granted & ~pick1;
    gnt1    = granted & pick1;

    // With no winner the port-0 fields are presented, which is the pick1 = 0 leg.
    mem_addr   = pick1 ? addr1  : addr0;
    mem_datain = pick1 ? wdata1 : wdata0;
    mem_memop  = pick1 ? memop1 : memop0;
    sel_we     = pick1 ? we1    : we0;

    unique case (mem_memop[1:0])
      OP_BYTE: bad = 1'b0;
      OP_HALF: bad = mem_addr[0];
      OP_WORD: bad = |mem_addr[1:0];
      default: bad = 1'b1;
    endcase

    mem_we = granted & sel_we & ~bad;
    last_d = granted ? pick1 : last_q;

    rvalid0_d = gnt0 & ~sel_we;
    rvalid1_d = gnt1 & ~sel_we;
    err0_d    = gnt0 & bad;
    err1_d    = gnt1 & bad;

    // Response data comes straight from the controller in the response cycle, then is held.
    rdata0 = rdata0_q;
    if (rvalid0_q) rdata0 = err0_q ? 32'h0 : mem_dataout;
    rdata1 = rdata1_q;
    if (rvalid1_q) rdata1 = err1_q ? 32'h0 : mem_dataout;
    rdata0_d = rdata0;
    rdata1_d = rdata1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q    <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= 32'h0;
      rdata1_q  <= 32'h0;
    end else begin
      last_q    <= last_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign err0    = err0_q;
  assign err1    = err1_q;

endmodule

// File: tb/tb_dmem_arb.sv
// Self-checking bench for dmem_arb: a dmem_ctrl stub, a transaction-level reference model
// checked every cycle, and directed vectors with literal expectations.
module tb_dmem_arb;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        req0, req1, we0, we1;
  logic [17:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic [2:0]  memop0, memop1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [17:0] mem_addr;
  logic [31:0] mem_datain;
  logic [2:0]  mem_memop;
  logic        mem_we;
  logic [31:0] mem_dataout = 32'h0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arb dut (
    .clk(clk), .rstn(rstn),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .memop0(memop0), .we0(we0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .memop1(memop1), .we1(we1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_memop(mem_memop),
    .mem_we(mem_we), .mem_dataout(mem_dataout)
  );

  // dmem_ctrl stand-in: word-organised, little-endian, registered read with sign/zero extension.
  logic [31:0] smem [0:65535];
  initial for (int i = 0; i < 65536; i++) smem[i] = 32'h0;

  function automatic logic [31:0] stub_rd(logic [31:0] w, logic [1:0] off, logic [2:0] op);
    logic [31:0] s;
    s = w >> (8 * int'(off));
    case (op[1:0])
      2'b00:   return op[2] ? {24'h0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
      2'b01:   return op[2] ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] stub_wr(logic [31:0] w, logic [1:0] off, logic [2:0] op,
                                          logic [31:0] d);
    logic [31:0] r;
    int o;
    r = w;
    o = 8 * int'(off);
    case (op[1:0])
      2'b00:   r[o +: 8] = d[7:0];
      2'b01:   r[o +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    mem_dataout <= stub_rd(smem[mem_addr[17:2]], mem_addr[1:0], mem_memop);
    if (mem_we) smem[mem_addr[17:2]] <= stub_wr(smem[mem_addr[17:2]], mem_addr[1:0], mem_memop, mem_datain);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Reference model: byte-addressed memory image plus pending response per port.
  logic [7:0] ref_mem [int];

  function automatic logic [7:0] ref_byte(int a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h0;
  endfunction

  function automatic int op_bytes(logic [2:0] op);
    return (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(int a, logic [2:0] op);
    logic [31:0] v;
    int n;
    n = op_bytes(op);
    v = 32'h0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = ref_byte(a + k);
    if (!op[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  function automatic bit is_bad(int a, logic [2:0] op);
    if (op[1:0] == 2'b11) return 1'b1;
    return (a % op_bytes(op)) != 0;
  endfunction

  initial begin : compare
    int          m_last;
    bit          m_pv [2];
    bit          m_pe [2];
    logic [31:0] m_pd [2];
    logic [31:0] m_hold [2];
    int          w, a;
    bit          c_rstn, bad, wr;
    logic [2:0]  op;
    logic [31:0] d;
    m_last = 1;
    for (int p = 0; p < 2; p++) begin
      m_pv[p] = 0; m_pe[p] = 0; m_pd[p] = 0; m_hold[p] = 0;
    end
    forever begin
      @(negedge clk);
      c_rstn = rstn;
      if (!c_rstn) begin
        m_last = 1;
        for (int p = 0; p < 2; p++) begin
          m_pv[p] = 0; m_pe[p] = 0; m_pd[p] = 0; m_hold[p] = 0;
        end
      end
      w = -1;
      if (c_rstn) begin
        if (req0 && req1)  w = (RR_EN && m_last == 0) ? 1 : 0;
        else if (req0)     w = 0;
        else if (req1)     w = 1;
      end
      a   = (w == 1) ? int'(addr1) : int'(addr0);
      op  = (w == 1) ? memop1 : memop0;
      d   = (w == 1) ? wdata1 : wdata0;
      wr  = (w == 1) ? we1 : we0;
      bad = is_bad(a, op);
      check("gnt0", gnt0, w == 0);
      check("gnt1", gnt1, w == 1);
      check("mem_we", mem_we, (w >= 0) && wr && !bad);
      check("mem_addr", mem_addr, a);
      check("mem_datain", mem_datain, d);
      check("mem_memop", mem_memop, op);
      check("rvalid0", rvalid0, m_pv[0]);
      check("rvalid1", rvalid1, m_pv[1]);
      check("err0", err0, m_pe[0]);
      check("err1", err1, m_pe[1]);
      check("rdata0", rdata0, m_pv[0] ? m_pd[0] : m_hold[0]);
      check("rdata1", rdata1, m_pv[1] ? m_pd[1] : m_hold[1]);
      @(posedge clk);
      if (c_rstn) begin
        for (int p = 0; p < 2; p++) begin
          if (m_pv[p]) m_hold[p] = m_pd[p];
          m_pv[p] = 0;
          m_pe[p] = 0;
        end
        if (w >= 0) begin
          m_last  = w;
          m_pe[w] = bad;
          if (!wr) begin
            m_pv[w] = 1;
            m_pd[w] = bad ? 32'h0 : ref_load(a, op);
          end else if (!bad) begin
            for (int k = 0; k < op_bytes(op); k++) ref_mem[a + k] = d[8*k +: 8];
          end
        end
      end
    end
  end

  task automatic set0(input logic r, input logic [17:0] a, input logic [31:0] d,
                      input logic [2:0] op, input logic w);
    req0 = r; addr0 = a; wdata0 = d; memop0 = op; we0 = w;
  endtask

  task automatic set1(input logic r, input logic [17:0] a, input logic [31:0] d,
                      input logic [2:0] op, input logic w);
    req1 = r; addr1 = a; wdata1 = d; memop1 = op; we1 = w;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    int g;
    rstn = 1'b0;
    set0(1'b1, 18'h0, 32'h0, 3'b010, 1'b0);
    set1(1'b1, 18'h4, 32'h0, 3'b010, 1'b0);
    @(negedge clk);
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_mem_we", mem_we, 0);
    step;
    step;
    rstn = 1'b1;

    // Persistent tie after reset release.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      g = gnt1 ? 1 : 0;
      check("tie_one_grant", gnt0 ^ gnt1, 1);
      check("tie_order", g, RR_EN ? (i % 2) : 0);
      step;
    end
    set0(1'b0, 18'h0, 32'h0, 3'b010, 1'b0);
    @(negedge clk);
    check("req0_drop_gnt1", gnt1, 1);
    step;
    set1(1'b0, 18'h0, 32'h0, 3'b010, 1'b0);

    // Port 0 word store then load.
    set0(1'b1, 18'h10, 32'hDEADBEEF, 3'b010, 1'b1);
    @(negedge clk);
    check("st_word_we", mem_we, 1);
    step;
    set0(1'b1, 18'h10, 32'h0, 3'b010, 1'b0);
    step;
    set0(1'b0, 18'h0, 32'h0, 3'b010, 1'b0);
    @(negedge clk);
    check("ld_word_rvalid0", rvalid0, 1);
    check("ld_word_rdata0", rdata0, 32'hDEADBEEF);
    check("ld_word_rvalid1", rvalid1, 0);
    step;

    // Port 1 byte store, then signed and zero-extended byte loads back to back.
    set1(1'b1, 18'h13, 32'h80, 3'b000, 1'b1);
    step;
    set1(1'b1, 18'h13, 32'h0, 3'b000, 1'b0);
    step;
    set1(1'b1, 18'h13, 32'h0, 3'b100, 1'b0);
    @(negedge clk);
    check("ld_sbyte_rdata1", rdata1, 32'hFFFFFF80);
    step;
    set1(1'b0, 18'h0, 32'h0, 3'b000, 1'b0);
    @(negedge clk);
    check("ld_ubyte_rdata1", rdata1, 32'h00000080);
    step;

    // Misaligned store, misaligned half load, reserved memop.
    set0(1'b1, 18'h2, 32'h12345678, 3'b010, 1'b1);
    @(negedge clk);
    check("mis_st_gnt0", gnt0, 1);
    check("mis_st_we", mem_we, 0);
    step;
    set0(1'b1, 18'h5, 32'h0, 3'b001, 1'b0);
    @(negedge clk);
    check("mis_st_err0", err0, 1);
    check("mis_st_rvalid0", rvalid0, 0);
    step;
    set0(1'b1, 18'h0, 32'h0, 3'b010, 1'b0);
    @(negedge clk);
    check("mis_ld_rvalid0", rvalid0, 1);
    check("mis_ld_err0", err0, 1);
    check("mis_ld_rdata0", rdata0, 32'h0);
    step;
    set0(1'b1, 18'h8, 32'h0, 3'b011, 1'b0);
    @(negedge clk);
    check("word0_unchanged", rdata0, 32'h0);
    check("word0_err0", err0, 0);
    step;
    set0(1'b0, 18'h0, 32'h0, 3'b010, 1'b0);
    @(negedge clk);
    check("rsvd_err0", err0, 1);
    check("rsvd_rvalid0", rvalid0, 1);
    step;

    // Load then store to the same word on consecutive cycles.
    set1(1'b1, 18'h10, 32'h0, 3'b010, 1'b0);
    step;
    set1(1'b0, 18'h0, 32'h0, 3'b010, 1'b0);
    set0(1'b1, 18'h10, 32'hCAFEF00D, 3'b010, 1'b1);
    @(negedge clk);
    check("ld_then_st_old", rdata1, 32'h80ADBEEF);
    step;
    set0(1'b1, 18'h10, 32'h0, 3'b010, 1'b0);
    step;
    set0(1'b0, 18'h0, 32'h0, 3'b010, 1'b0);
    @(negedge clk);
    check("st_then_ld_new", rdata0, 32'hCAFEF00D);
    step;

    // Contention between a good half store and a misaligned half store.
    set0(1'b1, 18'h20, 32'h1111, 3'b001, 1'b1);
    set1(1'b1, 18'h21, 32'h2222, 3'b001, 1'b1);
    step; step; step;
    set0(1'b0, 18'h0, 32'h0, 3'b010, 1'b0);
    step;
    set1(1'b0, 18'h0, 32'h0, 3'b010, 1'b0);
    step;

    // Reset arrives in the response cycle of a port-1 load.
    set1(1'b1, 18'h10, 32'h0, 3'b010, 1'b0);
    step;
    set1(1'b0, 18'h0, 32'h0, 3'b010, 1'b0);
    rstn = 1'b0;
    @(negedge clk);
    check("rst_drop_rvalid1", rvalid1, 0);
    step;
    rstn = 1'b1;
    step;
    step;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
